// File: rtl/fanout_1to8.sv
// rtl/fanout_1to8.sv - serial-to-parallel 1-to-8 fan-out with one-deep holding register
module fanout_1to8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] level
);

  // COLLECT gathers bits; FULL means all 8 collected bits wait for the holding register
  typedef enum logic {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] coll, coll_nxt;
  logic [7:0] hold, hold_nxt;
  logic [2:0] level_nxt;
  logic       out_valid_nxt;
  logic       accept;
  logic       drain;
  logic       hold_free;

  assign din_ready = (state == S_COLLECT);
  assign accept    = din_valid && din_ready;
  assign drain     = out_valid && out_ready;
  assign hold_free = !out_valid || out_ready;

  // slot 0 of the group is output a, slot 7 is output h
  assign a = hold[0];
  assign b = hold[1];
  assign c = hold[2];
  assign d = hold[3];
  assign e = hold[4];
  assign f = hold[5];
  assign g = hold[6];
  assign h = hold[7];

  // register all state; async reset clears collected and held data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_COLLECT;
      coll      <= 8'd0;
      hold      <= 8'd0;
      level     <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      coll      <= coll_nxt;
      hold      <= hold_nxt;
      level     <= level_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // next-state: collect bits, hand a complete group to the holding register when free
  always_comb begin
    state_nxt     = state;
    coll_nxt      = coll;
    hold_nxt      = hold;
    level_nxt     = level;
    out_valid_nxt = out_valid;

    if (clear) begin
      // clear drops the partial/full group and any bit offered this cycle,
      // but a drain of the holding register still completes
      state_nxt = S_COLLECT;
      level_nxt = 3'd0;
      if (drain) begin
        out_valid_nxt = 1'b0;
      end
    end else if (state == S_COLLECT) begin
      if (drain) begin
        out_valid_nxt = 1'b0;
      end
      if (accept) begin
        if (level == 3'd7) begin
          if (hold_free) begin
            // eighth bit goes straight into the holding register with no bubble
            hold_nxt      = {din, coll[6:0]};
            out_valid_nxt = 1'b1;
            level_nxt     = 3'd0;
          end else begin
            coll_nxt[7] = din;
            state_nxt   = S_FULL;
          end
        end else begin
          coll_nxt[level] = din;
          level_nxt       = level + 3'd1;
        end
      end
    end else begin
      if (drain) begin
        hold_nxt      = coll;
        out_valid_nxt = 1'b1;
        state_nxt     = S_COLLECT;
        level_nxt     = 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_fanout_1to8.sv
// tb/tb_fanout_1to8.sv - randomized self-checking bench for fanout_1to8
module tb_fanout_1to8;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       a, b, c, d, e, f, g, h;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;

  int errors;
  int checks;

  bit         pq[$];
  logic [7:0] m_hold;
  bit         m_ov;
  int         ov_count;

  fanout_1to8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] group_obs();
    return {h, g, f, e, d, c, b, a};
  endfunction

  task automatic compare_all();
    int exp_level;
    exp_level = (pq.size() == 8) ? 7 : pq.size();
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("group", group_obs(), m_hold);
    chk("din_ready", din_ready, pq.size() < 8);
    chk("level", level, exp_level);
  endtask

  task automatic model_reset();
    pq.delete();
    m_hold = 8'd0;
    m_ov   = 1'b0;
  endtask

  // one clock cycle: drive inputs, advance the reference model, compare
  task automatic cycle(input bit v, input bit dv, input bit r, input bit cl);
    bit drain, free, acc;
    din_valid = v;
    din       = dv;
    out_ready = r;
    clear     = cl;
    drain = m_ov && r;
    free  = !m_ov || r;
    acc   = v && (pq.size() < 8);
    @(posedge clk);
    #1;
    if (cl) begin
      pq.delete();
      if (drain) m_ov = 1'b0;
    end else begin
      if (acc) pq.push_back(dv);
      if (drain) m_ov = 1'b0;
      if (pq.size() == 8 && free) begin
        for (int i = 0; i < 8; i++) m_hold[i] = pq[i];
        m_ov = 1'b1;
        pq.delete();
      end
    end
    if (m_ov) ov_count++;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] bits, input bit r);
    for (int i = 0; i < 8; i++) cycle(1'b1, bits[i], r, 1'b0);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din       = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    errors   = 0;
    checks   = 0;
    ov_count = 0;

    do_reset();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_din_ready", din_ready, 1'b1);
    chk("reset_level", level, 3'd0);
    chk("reset_group", group_obs(), 8'h00);

    // stream 1,0,1,1,0,0,1,0 (a first)
    pat = 8'b0100_1101;
    send_byte(pat, 1'b1);
    chk("first_group_valid", out_valid, 1'b1);
    chk("first_group", group_obs(), 8'h4D);
    chk("first_group_level", level, 3'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // 24 bits back-to-back: three single-cycle groups
    ov_count = 0;
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("three_groups", ov_count, 3);

    // stall: 16 bits with out_ready low, then one drain cycle
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    chk("stall_din_ready", din_ready, 1'b0);
    chk("stall_level", level, 3'd7);
    chk("stall_group", group_obs(), 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("refill_valid", out_valid, 1'b1);
    chk("refill_group", group_obs(), 8'h3C);
    chk("refill_ready", din_ready, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // 5 bits, clear with a 6th bit, then all ones
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("clear_level", level, 3'd0);
    send_byte(8'hFF, 1'b1);
    chk("clear_group", group_obs(), 8'hFF);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);

    // gaps: valid toggling across 8 accepted bits
    pat = 8'b1001_0110;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, pat[i], 1'b1, 1'b0);
      cycle(1'b0, ~pat[i], 1'b1, 1'b0);
    end
    chk("gap_group", group_obs(), pat);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    // async reset mid-cycle while FULL with a group held
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b0);
    chk("pre_reset_full", din_ready, 1'b0);
    chk("pre_reset_valid", out_valid, 1'b1);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_din_ready", din_ready, 1'b1);
    chk("async_level", level, 3'd0);
    chk("async_group", group_obs(), 8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    send_byte(8'h81, 1'b1);
    chk("post_reset_group", group_obs(), 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
